// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider: state encoding,
// default width, and two's-complement magnitude/negation functions.
package div_pkg;

  localparam int DIV_W_DEFAULT = 8;
  localparam int DIV_W_MAX     = 64;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

  // Operates at DIV_W_MAX width; callers truncate back to their own width,
  // which is exact for two's-complement negation.
  function automatic logic [DIV_W_MAX-1:0] div_neg(input logic [DIV_W_MAX-1:0] v);
    return ~v + DIV_W_MAX'(1);
  endfunction

  function automatic logic [DIV_W_MAX-1:0] div_mag(input logic [DIV_W_MAX-1:0] v,
                                                    input logic              is_neg);
    return is_neg ? div_neg(v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift the next dividend bit into the
// partial remainder and trial-subtract the divisor magnitude.
module div_step #(
  parameter int W = 8
) (
  input  logic [W:0]   rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] dvs,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {2'b00, dvs};
  assign q_bit   = ~diff[W+1];
  assign rem_out = q_bit ? diff[W:0] : shifted[W:0];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned restoring divider with valid/ready channels.
// Optional macro DIV_ERR_FLAG_EN enables the divide-by-zero/overflow err flag.
module div_seq
  import div_pkg::*;
#(
  parameter int W = DIV_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_signed,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         err
);

  // state    | meaning
  // DIV_IDLE | waiting for operands, in_ready high
  // DIV_CALC | one restoring iteration per clock, W clocks
  // DIV_FIX  | apply result signs for signed operations
  // DIV_DONE | result held until out_ready

  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  div_state_t   state, state_nxt;
  logic         sgn_q, dvd_neg_q, dvs_neg_q;
  logic [W-1:0] dvd_sr, dvs_mag, cnt;
  logic [W:0]   prem, prem_nxt;
  logic         q_bit;

  logic         accept, dvd_neg_in, dvs_neg_in, div0, ovf, special;
  logic [W-1:0] q_fix, r_fix;

  assign accept     = in_valid && in_ready;
  assign dvd_neg_in = in_signed && dividend[W-1];
  assign dvs_neg_in = in_signed && divisor[W-1];
  assign div0       = (divisor == '0);
  assign ovf        = in_signed && (dividend == MIN_NEG) && (divisor == '1);
  assign special    = div0 || ovf;

  assign q_fix = (sgn_q && (dvd_neg_q ^ dvs_neg_q)) ? W'(div_neg(DIV_W_MAX'(dvd_sr))) : dvd_sr;
  assign r_fix = (sgn_q && dvd_neg_q) ? W'(div_neg(DIV_W_MAX'(prem[W-1:0]))) : prem[W-1:0];

  div_step #(.W(W)) u_step (
    .rem_in  (prem),
    .bit_in  (dvd_sr[W-1]),
    .dvs     (dvs_mag),
    .rem_out (prem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (in_valid) state_nxt = special ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt == '0) state_nxt = DIV_FIX;
      DIV_FIX:  state_nxt = DIV_DONE;
      DIV_DONE: if (out_ready) state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == DIV_IDLE);
    out_valid = (state == DIV_DONE);
  end

  // The dividend register shifts out dividend bits and shifts in quotient
  // bits, so after W iterations it holds the unsigned quotient.
  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_q     <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      dvd_sr    <= '0;
      dvs_mag   <= '0;
      prem      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (accept) begin
            sgn_q     <= in_signed;
            dvd_neg_q <= dvd_neg_in;
            dvs_neg_q <= dvs_neg_in;
            dvd_sr    <= W'(div_mag(DIV_W_MAX'(dividend), dvd_neg_in));
            dvs_mag   <= W'(div_mag(DIV_W_MAX'(divisor), dvs_neg_in));
            prem      <= '0;
            cnt       <= W'(W - 1);
            if (div0) begin
              quotient  <= '1;
              remainder <= dividend;
            end else if (ovf) begin
              quotient  <= dividend;
              remainder <= '0;
            end
          end
        end
        DIV_CALC: begin
          prem   <= prem_nxt;
          dvd_sr <= {dvd_sr[W-2:0], q_bit};
          if (cnt != '0) cnt <= cnt - W'(1);
        end
        DIV_FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ERR_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst)                                err <= 1'b0;
    else if (state == DIV_IDLE && accept)   err <= special;
    else if (state == DIV_FIX)              err <= 1'b0;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq (W=8): vector table, random model-checked
// operations, backpressure and mid-operation reset sequences.
module tb_div_seq;

  typedef struct {
    logic       sgn;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       e;
    int         lat;
  } vec_t;

`ifdef DIV_ERR_FLAG_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, in_signed, out_valid, out_ready, err;
  logic [7:0] dividend, divisor, quotient, remainder;

  int   checks = 0;
  int   errors = 0;
  vec_t sb_q[$];
  vec_t tbl[12];

  div_seq #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic s, input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    logic signed [7:0] sa, sb;
    sa = a;
    sb = b;
    v.sgn = s; v.a = a; v.b = b; v.e = 1'b0; v.lat = 10;
    if (b == 8'h00) begin
      v.q = 8'hFF; v.r = a; v.e = ERR_EN; v.lat = 1;
    end else if (s && a == 8'h80 && b == 8'hFF) begin
      v.q = a; v.r = 8'h00; v.e = ERR_EN; v.lat = 1;
    end else if (s) begin
      v.q = 8'(sa / sb); v.r = 8'(sa % sb);
    end else begin
      v.q = a / b; v.r = a % b;
    end
    return v;
  endfunction

  // Caller is positioned 1 time unit after a rising edge.
  task automatic run_op(input vec_t v, input int hold);
    vec_t e;
    int   lat;
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_signed = v.sgn;
    dividend  = v.a;
    divisor   = v.b;
    chk("in_ready_at_accept", 32'(in_ready), 32'd1);
    sb_q.push_back(v);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      in_valid  = 1'b0;
      dividend  = 8'($urandom);
      divisor   = 8'($urandom);
      in_signed = 1'($urandom);
    end while (!out_valid && lat < 60);
    e = sb_q.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    chk("quotient", 32'(quotient), 32'(e.q));
    chk("remainder", 32'(remainder), 32'(e.r));
    chk("err", 32'(err), 32'(e.e));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_quotient", 32'(quotient), 32'(e.q));
      chk("hold_remainder", 32'(remainder), 32'(e.r));
      chk("hold_err", 32'(err), 32'(e.e));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic quiet;
    tbl[0]  = '{1'b1, 8'd100, 8'd7,  8'h0E, 8'h02, 1'b0,   10};
    tbl[1]  = '{1'b1, 8'h9C,  8'd7,  8'hF2, 8'hFE, 1'b0,   10};
    tbl[2]  = '{1'b1, 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0,   10};
    tbl[3]  = '{1'b0, 8'hC8,  8'd3,  8'h42, 8'h02, 1'b0,   10};
    tbl[4]  = '{1'b1, 8'hC8,  8'd3,  8'hEE, 8'hFE, 1'b0,   10};
    tbl[5]  = '{1'b0, 8'h5A,  8'h00, 8'hFF, 8'h5A, ERR_EN, 1};
    tbl[6]  = '{1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, ERR_EN, 1};
    tbl[7]  = '{1'b1, 8'h5A,  8'h00, 8'hFF, 8'h5A, ERR_EN, 1};
    tbl[8]  = '{1'b0, 8'h80,  8'hFF, 8'h00, 8'h80, 1'b0,   10};
    tbl[9]  = '{1'b0, 8'hFF,  8'h01, 8'hFF, 8'h00, 1'b0,   10};
    tbl[10] = '{1'b1, 8'h80,  8'h01, 8'h80, 8'h00, 1'b0,   10};
    tbl[11] = '{1'b1, 8'h7F,  8'h80, 8'h00, 8'h7F, 1'b0,   10};

    rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; out_ready = 1'b1;
    dividend = 8'h00; divisor = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_err", 32'(err), 32'd0);

    for (int i = 0; i < 12; i++) run_op(tbl[i], 0);

    // Backpressure, then an accept on the cycle right after the handshake.
    run_op(tbl[0], 5);
    run_op(tbl[4], 0);

    for (int i = 0; i < 20; i++) begin
      logic       s;
      logic [7:0] a, b;
      s = 1'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_op(model(s, a, b), (i % 5 == 0) ? 2 : 0);
    end

    // Reset during the 4th CALC cycle aborts the operation.
    run_op(tbl[1], 0);
    in_valid = 1'b1; in_signed = 1'b1; dividend = 8'd100; divisor = 8'd7;
    chk("abort_accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    quiet = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) quiet = 1'b0;
    end
    chk("abort_no_out_valid", 32'(quiet), 32'd1);
    run_op(tbl[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
